logic_unit_arbiter: RTL and testbench

// - Shares one WIDTH-bit bitwise logic unit (AND/OR/NOR/XOR) between two requesters.
// - Sits beside the ALU; requesters are the main datapath (port 0) and the address-generation path (port 1).
// - Two-request round-robin arbitration; operands captured on grant; one registered result with a per-port done pulse.

---
 rtl/logic_unit_arbiter.sv | 131 +++++++++++++
 tb/tb_logic_unit_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/logic_unit_arbiter.sv
// Two-port round-robin arbiter sharing one bitwise logic unit (AND/OR/NOR/XOR).
// Define LOGIC_ARB_ZERO_FLAG_EN to add a registered ZERO flag that tracks Y.
module logic_unit_arbiter #(
   parameter int unsigned WIDTH  = 32,
   parameter logic [1:0]  OP_AND = 2'b00,
   parameter logic [1:0]  OP_OR  = 2'b01,
   parameter logic [1:0]  OP_NOR = 2'b10,
   parameter logic [1:0]  OP_XOR = 2'b11
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             REQ0,
   input  logic [1:0]       OP0,
   input  logic [WIDTH-1:0] A0,
   input  logic [WIDTH-1:0] B0,
   input  logic             REQ1,
   input  logic [1:0]       OP1,
   input  logic [WIDTH-1:0] A1,
   input  logic [WIDTH-1:0] B1,
   output logic             GNT0,
   output logic             GNT1,
   output logic             DONE0,
   output logic             DONE1,
   output logic [WIDTH-1:0] Y,
`ifdef LOGIC_ARB_ZERO_FLAG_EN
   output logic             BUSY,
   output logic             ZERO
`else
   output logic             BUSY
`endif
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_EXEC,
      S_RESP
   } state_t;

   state_t           state_q;
   logic             ptr_q;
   logic [1:0]       op_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic             gnt0_q;
   logic             gnt1_q;
   logic             done0_q;
   logic             done1_q;
   logic             busy_q;
   logic [WIDTH-1:0] y_q;
   logic [WIDTH-1:0] y_d;
   logic             pick1;
`ifdef LOGIC_ARB_ZERO_FLAG_EN
   logic             zero_q;
`endif

   // ptr_q is the last granted port; on a tie the other port wins
   assign pick1 = REQ1 & (~REQ0 | ~ptr_q);

   always_comb begin
      y_d = '0;
      case (op_q)
         OP_AND:  y_d = a_q & b_q;
         OP_OR:   y_d = a_q | b_q;
         OP_NOR:  y_d = ~(a_q | b_q);
         default: y_d = a_q ^ b_q;
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q <= S_IDLE;
         ptr_q   <= 1'b1;
         op_q    <= 2'b00;
         a_q     <= '0;
         b_q     <= '0;
         gnt0_q  <= 1'b0;
         gnt1_q  <= 1'b0;
         done0_q <= 1'b0;
         done1_q <= 1'b0;
         busy_q  <= 1'b0;
         y_q     <= '0;
`ifdef LOGIC_ARB_ZERO_FLAG_EN
         zero_q  <= 1'b0;
`endif
      end else begin
         gnt0_q  <= 1'b0;
         gnt1_q  <= 1'b0;
         done0_q <= 1'b0;
         done1_q <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (REQ0 | REQ1) begin
                  state_q <= S_EXEC;
                  busy_q  <= 1'b1;
                  ptr_q   <= pick1;
                  op_q    <= pick1 ? OP1 : OP0;
                  a_q     <= pick1 ? A1 : A0;
                  b_q     <= pick1 ? B1 : B0;
                  gnt0_q  <= ~pick1;
                  gnt1_q  <= pick1;
               end
            end
            S_EXEC: begin
               state_q <= S_RESP;
               y_q     <= y_d;
               done0_q <= ~ptr_q;
               done1_q <= ptr_q;
`ifdef LOGIC_ARB_ZERO_FLAG_EN
               zero_q  <= (y_d == '0);
`endif
            end
            S_RESP: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign GNT0  = gnt0_q;
   assign GNT1  = gnt1_q;
   assign DONE0 = done0_q;
   assign DONE1 = done1_q;
   assign BUSY  = busy_q;
   assign Y     = y_q;
`ifdef LOGIC_ARB_ZERO_FLAG_EN
   assign ZERO  = zero_q;
`endif

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed bench for logic_unit_arbiter: vector table plus reset,
// round-robin and mid-operation reset sequences.
module tb_logic_unit_arbiter;

   localparam logic [1:0] AND_ = 2'b00;
   localparam logic [1:0] OR_  = 2'b01;
   localparam logic [1:0] NOR_ = 2'b10;
   localparam logic [1:0] XOR_ = 2'b11;

   logic        CLK;
   logic        RST;
   logic        REQ0;
   logic [1:0]  OP0;
   logic [31:0] A0;
   logic [31:0] B0;
   logic        REQ1;
   logic [1:0]  OP1;
   logic [31:0] A1;
   logic [31:0] B1;
   logic        GNT0;
   logic        GNT1;
   logic        DONE0;
   logic        DONE1;
   logic [31:0] Y;
   logic        BUSY;
`ifdef LOGIC_ARB_ZERO_FLAG_EN
   logic        ZERO;
`endif

   logic_unit_arbiter #(.WIDTH(32)) dut (
      .CLK   (CLK),
      .RST   (RST),
      .REQ0  (REQ0),
      .OP0   (OP0),
      .A0    (A0),
      .B0    (B0),
      .REQ1  (REQ1),
      .OP1   (OP1),
      .A1    (A1),
      .B1    (B1),
      .GNT0  (GNT0),
      .GNT1  (GNT1),
      .DONE0 (DONE0),
      .DONE1 (DONE1),
      .Y     (Y),
`ifdef LOGIC_ARB_ZERO_FLAG_EN
      .BUSY  (BUSY),
      .ZERO  (ZERO)
`else
      .BUSY  (BUSY)
`endif
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      logic        r0;
      logic [1:0]  o0;
      logic [31:0] a0;
      logic [31:0] b0;
      logic        r1;
      logic [1:0]  o1;
      logic [31:0] a1;
      logic [31:0] b1;
      logic        ep;
      logic [31:0] ey;
   } vec_t;

   vec_t tbl [9];
   int   n_cmp = 0;
   int   n_err = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic run_vec(input vec_t v);
      logic seen;
      seen = 1'b0;
      @(negedge CLK);
      REQ0 = v.r0; OP0 = v.o0; A0 = v.a0; B0 = v.b0;
      REQ1 = v.r1; OP1 = v.o1; A1 = v.a1; B1 = v.b1;
      for (int c = 0; c < 8 && !seen; c++) begin
         @(posedge CLK); #1;
         seen = GNT0 | GNT1;
      end
      chk("gnt_seen", {31'd0, seen}, 32'd1);
      chk("gnt_port", {30'd0, GNT1, GNT0}, v.ep ? 32'd2 : 32'd1);
      chk("busy_exec", {31'd0, BUSY}, 32'd1);
      // disturb operands after the grant edge
      REQ0 = 1'b0; REQ1 = 1'b0;
      A0 = '0; B0 = '1; A1 = '0; B1 = '1;
      OP0 = OP0 ^ 2'b11; OP1 = OP1 ^ 2'b11;
      @(posedge CLK); #1;
      chk("done_port", {30'd0, DONE1, DONE0}, v.ep ? 32'd2 : 32'd1);
      chk("y", Y, v.ey);
      chk("busy_resp", {31'd0, BUSY}, 32'd1);
      chk("gnt_low", {30'd0, GNT1, GNT0}, 32'd0);
`ifdef LOGIC_ARB_ZERO_FLAG_EN
      chk("zero", {31'd0, ZERO}, {31'd0, v.ey == 32'd0});
`endif
      @(posedge CLK); #1;
      chk("idle", {29'd0, BUSY, DONE1, DONE0}, 32'd0);
      chk("y_hold", Y, v.ey);
   endtask

   task automatic chk_reset_outs(input string nm);
      chk({nm, "_flags"}, {28'd0, GNT0, GNT1, DONE0, DONE1}, 32'd0);
      chk({nm, "_busy"}, {31'd0, BUSY}, 32'd0);
      chk({nm, "_y"}, Y, 32'd0);
`ifdef LOGIC_ARB_ZERO_FLAG_EN
      chk({nm, "_zero"}, {31'd0, ZERO}, 32'd0);
`endif
   endtask

   int   ng;
   int   gcyc [5];
   logic gport [5];
   logic seen;

   initial begin
      tbl[0] = '{1, AND_, 32'hF0F0_FFFF, 32'h0FF0_00FF, 0, AND_, 0, 0, 0, 32'h00F0_00FF};
      tbl[1] = '{0, AND_, 0, 0, 1, OR_,  32'hAAAA_5555, 32'h0F0F_0F0F, 1, 32'hAFAF_5F5F};
      tbl[2] = '{0, AND_, 0, 0, 1, NOR_, 32'hAAAA_5555, 32'h0F0F_0F0F, 1, 32'h5050_A0A0};
      tbl[3] = '{0, AND_, 0, 0, 1, XOR_, 32'hAAAA_5555, 32'h0F0F_0F0F, 1, 32'hA5A5_5A5A};
      tbl[4] = '{1, XOR_, 32'h1234_5678, 32'hFFFF_FFFF, 1, OR_, 32'h1, 32'h2, 0, 32'hEDCB_A987};
      tbl[5] = '{1, AND_, 32'hFFFF_FFFF, 32'h1, 1, AND_, 32'h1234_5678, 32'h0F0F_0F0F, 1, 32'h0204_0608};
      tbl[6] = '{1, NOR_, 32'h0, 32'h0, 0, AND_, 0, 0, 0, 32'hFFFF_FFFF};
      tbl[7] = '{1, AND_, 32'hFFFF_0000, 32'h0000_FFFF, 0, AND_, 0, 0, 0, 32'h0};
      tbl[8] = '{0, AND_, 0, 0, 1, XOR_, 32'h3, 32'h2, 1, 32'h1};

      RST = 1'b0;
      REQ0 = 0; OP0 = 0; A0 = 0; B0 = 0;
      REQ1 = 0; OP1 = 0; A1 = 0; B1 = 0;
      #3;
      chk_reset_outs("reset");
      @(negedge CLK);
      RST = 1'b1;

      foreach (tbl[i]) run_vec(tbl[i]);

      // both requests held from reset: grants alternate every 3 cycles
      @(negedge CLK);
      RST = 1'b0;
      REQ0 = 1; OP0 = OR_; A0 = 32'h1; B0 = 32'h2;
      REQ1 = 1; OP1 = OR_; A1 = 32'h4; B1 = 32'h8;
      #1;
      chk_reset_outs("rr_reset");
      @(negedge CLK);
      RST = 1'b1;
      ng = 0;
      for (int c = 0; c < 13; c++) begin
         @(posedge CLK); #1;
         chk("no_dbl_gnt", {31'd0, GNT0 & GNT1}, 32'd0);
         chk("no_dbl_done", {31'd0, DONE0 & DONE1}, 32'd0);
         if (c == 1) chk("rr_y0", Y, 32'h3);
         if (c == 4) chk("rr_y1", Y, 32'hC);
         if (GNT0 | GNT1) begin
            if (ng < 5) begin
               gcyc[ng]  = c;
               gport[ng] = GNT1;
            end
            ng++;
         end
      end
      REQ0 = 0; REQ1 = 0;
      chk("rr_count", ng, 5);
      for (int i = 0; i < 5; i++) begin
         chk("rr_port", {31'd0, gport[i]}, i % 2);
         chk("rr_cycle", gcyc[i], 3 * i);
      end
      repeat (3) @(posedge CLK);

      // reset while in EXEC: op discarded, no DONE afterwards
      @(negedge CLK);
      REQ0 = 1; OP0 = AND_; A0 = 32'hFFFF_FFFF; B0 = 32'h1234_5678;
      seen = 1'b0;
      for (int c = 0; c < 8 && !seen; c++) begin
         @(posedge CLK); #1;
         seen = GNT0;
      end
      chk("mid_gnt_seen", {31'd0, seen}, 32'd1);
      REQ0 = 0;
      #2 RST = 1'b0;
      #1;
      chk_reset_outs("mid_exec");
      @(negedge CLK);
      RST = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(posedge CLK); #1;
         chk("no_done_after_rst", {30'd0, DONE1, DONE0}, 32'd0);
      end

      // reset while in RESP with a valid result
      @(negedge CLK);
      REQ0 = 1; OP0 = AND_; A0 = 32'hFFFF_FFFF; B0 = 32'h1234_5678;
      @(posedge CLK); #1;
      REQ0 = 0;
      @(posedge CLK); #1;
      chk("resp_y", Y, 32'h1234_5678);
      chk("resp_done", {30'd0, DONE1, DONE0}, 32'd1);
      #2 RST = 1'b0;
      #1;
      chk_reset_outs("mid_resp");
      @(negedge CLK);
      RST = 1'b1;

      run_vec(tbl[0]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
